// File: rtl/net_pkg.sv
// Shared types for the two-requester network arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package net_pkg;

  localparam int DATA_W = 4;

  typedef logic [0:DATA_W-1] data_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/net_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the network.
// Latency: none (wires only).
// Backpressure: rdy_a/rdy_b toward requesters, net_busy from the network.
// Ports: requester A (val_a, data1_a, data2_a, rdy_a), requester B (val_b_in,
//        data1_b_in, data2_b_in, rdy_b), network (val_n, data1_n, data2_n,
//        net_busy), sticky abort flag err.
interface net_arbiter_if;
  import net_pkg::*;

  logic  val_a;
  data_t data1_a;
  data_t data2_a;
  logic  rdy_a;

  logic  val_b_in;
  data_t data1_b_in;
  data_t data2_b_in;
  logic  rdy_b;

  logic  net_busy;
  logic  val_n;
  data_t data1_n;
  data_t data2_n;
  logic  err;

  // master: the environment (requesters + network)
  modport master (
    output val_a, data1_a, data2_a, val_b_in, data1_b_in, data2_b_in, net_busy,
    input  rdy_a, rdy_b, val_n, data1_n, data2_n, err
  );

  // slave: the arbiter
  modport slave (
    input  val_a, data1_a, data2_a, val_b_in, data1_b_in, data2_b_in, net_busy,
    output rdy_a, rdy_b, val_n, data1_n, data2_n, err
  );

endinterface

// File: rtl/net_slot.sv
// One-entry message buffer for a single requester.
// Latency: data captured on the load edge, visible on full/data1/data2 next cycle.
// Backpressure: rdy is a flop equal to !full; low during reset, never depends on val.
// Ports: clk, rst_n, load (capture), clear (release), data1_in/data2_in,
//        full, data1, data2, rdy.
module net_slot
  import net_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  clear,
  input  data_t data1_in,
  input  data_t data2_in,
  output logic  full,
  output data_t data1,
  output data_t data2,
  output logic  rdy
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      data1 <= '0;
      data2 <= '0;
      rdy   <= 1'b0;
    end else begin
      if (clear) begin
        full <= 1'b0;
      end else if (load) begin
        full  <= 1'b1;
        data1 <= data1_in;
        data2 <= data2_in;
      end
      // rdy tracks the next value of full so it stays a clean flop output.
      // load and clear never coincide: load needs rdy, clear needs full.
      rdy <= clear | (~load & ~full);
    end
  end

endmodule

// File: rtl/net_arbiter.sv
// Round-robin arbiter moving one-entry requester slots A/B onto the network.
// Latency: val_n rises two cycles after val_x is offered; one IDLE cycle between writes.
// Backpressure: net_busy holds the write; TIMEOUT busy cycles drop it and set sticky err.
// Ports: clk, rst_n (async, active low), bus (net_arbiter_if.slave).
module net_arbiter
  import net_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  net_arbiter_if.slave  bus
);

  localparam logic [3:0] TIMEOUT_M1 = 4'(TIMEOUT - 1);

  logic    full_a, full_b, rdy_a_q, rdy_b_q;
  logic    load_a, load_b, clr_a, clr_b, done;
  data_t   s1_a, s2_a, s1_b, s2_b;
  state_t  state_q, state_d;
  req_id_t sel_q, sel_d, last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic    err_q, err_d;
  logic    val_n_c;
  data_t   d1_n_c, d2_n_c;

  assign load_a = bus.val_a    & rdy_a_q;
  assign load_b = bus.val_b_in & rdy_b_q;

  net_slot u_slot_a (
    .clk(clk), .rst_n(rst_n), .load(load_a), .clear(clr_a),
    .data1_in(bus.data1_a), .data2_in(bus.data2_a),
    .full(full_a), .data1(s1_a), .data2(s2_a), .rdy(rdy_a_q)
  );

  net_slot u_slot_b (
    .clk(clk), .rst_n(rst_n), .load(load_b), .clear(clr_b),
    .data1_in(bus.data1_b_in), .data2_in(bus.data2_b_in),
    .full(full_b), .data1(s1_b), .data2(s2_b), .rdy(rdy_b_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= ID_A;
      last_q  <= ID_B;   // A wins the first tie
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done    = 1'b0;
    clr_a   = 1'b0;
    clr_b   = 1'b0;
    val_n_c = 1'b0;
    d1_n_c  = '0;
    d2_n_c  = '0;
    case (state_q)
      IDLE: begin
        if (full_a | full_b) begin
          if (full_a & full_b) sel_d = (last_q == ID_B) ? ID_A : ID_B;
          else if (full_a)     sel_d = ID_A;
          else                 sel_d = ID_B;
          cnt_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        val_n_c = 1'b1;
        d1_n_c  = (sel_q == ID_A) ? s1_a : s1_b;
        d2_n_c  = (sel_q == ID_A) ? s2_a : s2_b;
        if (!bus.net_busy) begin
          done = 1'b1;
        end else if (cnt_q == TIMEOUT_M1) begin
          // this busy cycle is the TIMEOUT-th one: drop the message
          done  = 1'b1;
          err_d = 1'b1;
        end else if (cnt_q != 4'hF) begin
          cnt_d = cnt_q + 4'd1;
        end
        if (done) begin
          clr_a   = (sel_q == ID_A);
          clr_b   = (sel_q == ID_B);
          last_d  = sel_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rdy_a   = rdy_a_q;
  assign bus.rdy_b   = rdy_b_q;
  assign bus.val_n   = val_n_c;
  assign bus.data1_n = d1_n_c;
  assign bus.data2_n = d2_n_c;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_net_arbiter.sv
module tb_net_arbiter;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d2;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  net_arbiter_if bus ();

  net_arbiter #(.TIMEOUT(15)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("post_reset_rdy_a", bus.rdy_a, 1);
  endtask

  // Scoreboard: a message completes when val_n is high and the network is not busy.
  always @(negedge clk) begin
    if (rst_n && bus.val_n && !bus.net_busy) begin
      exp_t e;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%0h/%0h expected=none", bus.data1_n, bus.data2_n);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_data1", bus.data1_n, e.d1);
        chk("sb_data2", bus.data2_n, e.d2);
      end
    end
  end

  task automatic both_round(input logic [3:0] a1, input logic [3:0] b1);
    bus.val_a = 1; bus.data1_a = a1; bus.data2_a = 4'h2;
    bus.val_b_in = 1; bus.data1_b_in = b1; bus.data2_b_in = 4'hA;
    sb.push_back('{a1, 4'h2});
    sb.push_back('{b1, 4'hA});
    cyc(1);
    bus.val_a = 0; bus.val_b_in = 0;
    chk("rr_rdy_a_full", bus.rdy_a, 0);
    chk("rr_rdy_b_full", bus.rdy_b, 0);
    cyc(1);
    chk("rr_first_val", bus.val_n, 1);
    chk("rr_first_is_a", bus.data1_n, a1);
    cyc(2);
    chk("rr_second_is_b", bus.data1_n, b1);
    cyc(1);
    chk("rr_idle_val", bus.val_n, 0);
    chk("rr_rdy_b_back", bus.rdy_b, 1);
  endtask

  initial begin
    bus.val_a = 0; bus.data1_a = '0; bus.data2_a = '0;
    bus.val_b_in = 0; bus.data1_b_in = '0; bus.data2_b_in = '0;
    bus.net_busy = 0;

    // Reset state
    #2;
    chk("rst_rdy_a", bus.rdy_a, 0);
    chk("rst_rdy_b", bus.rdy_b, 0);
    chk("rst_val_n", bus.val_n, 0);
    chk("rst_data1_n", bus.data1_n, 0);
    chk("rst_err", bus.err, 0);
    #10;
    rst_n = 1;
    #1;
    chk("rel_rdy_a_before_edge", bus.rdy_a, 0);
    cyc(1);
    chk("rel_rdy_a", bus.rdy_a, 1);
    chk("rel_rdy_b", bus.rdy_b, 1);

    // A alone: 3/5 appears two cycles after it is offered, for one cycle
    bus.val_a = 1; bus.data1_a = 4'h3; bus.data2_a = 4'h5;
    sb.push_back('{4'h3, 4'h5});
    cyc(1);
    bus.val_a = 0;
    chk("a_only_rdy_low", bus.rdy_a, 0);
    chk("a_only_no_val_yet", bus.val_n, 0);
    cyc(1);
    chk("a_only_val", bus.val_n, 1);
    chk("a_only_d1", bus.data1_n, 4'h3);
    chk("a_only_d2", bus.data2_n, 4'h5);
    cyc(1);
    chk("a_only_val_drop", bus.val_n, 0);
    chk("a_only_d1_zero", bus.data1_n, 0);
    chk("a_only_rdy_back", bus.rdy_a, 1);
    chk("a_only_sb_empty", sb.size(), 0);

    // Ties from reset: A first, then strict alternation
    do_reset();
    both_round(4'h1, 4'h9);
    both_round(4'h4, 4'hC);
    chk("rr_sb_empty", sb.size(), 0);

    // Busy for 3 cycles: val_n held 4 cycles; B captured meanwhile
    bus.val_a = 1; bus.data1_a = 4'h6; bus.data2_a = 4'h7;
    sb.push_back('{4'h6, 4'h7});
    cyc(1);
    bus.val_a = 0; bus.net_busy = 1;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      chk("stall_val", bus.val_n, 1);
      chk("stall_d1", bus.data1_n, 4'h6);
      chk("stall_d2", bus.data2_n, 4'h7);
      chk("stall_err", bus.err, 0);
      if (i == 0) begin
        bus.val_b_in = 1; bus.data1_b_in = 4'h8; bus.data2_b_in = 4'hB;
        sb.push_back('{4'h8, 4'hB});
      end
      if (i == 1) begin
        chk("stall_b_captured", bus.rdy_b, 0);
        bus.val_b_in = 0;
      end
      if (i == 3) bus.net_busy = 0;
      cyc(1);
    end
    chk("stall_val_done", bus.val_n, 0);
    cyc(2);
    chk("stall_b_done", bus.val_n, 0);
    chk("stall_sb_empty", sb.size(), 0);

    // Timeout: A held busy for 15 cycles is dropped, pending B then served
    bus.val_a = 1; bus.data1_a = 4'hC; bus.data2_a = 4'hD;
    bus.val_b_in = 1; bus.data1_b_in = 4'hE; bus.data2_b_in = 4'hF;
    bus.net_busy = 1;
    sb.push_back('{4'hE, 4'hF});
    cyc(1);
    bus.val_a = 0; bus.val_b_in = 0;
    cyc(1);
    for (int i = 0; i < 15; i++) begin
      chk("to_val_held", bus.val_n, 1);
      chk("to_err_low", bus.err, 0);
      cyc(1);
    end
    chk("to_val_dropped", bus.val_n, 0);
    chk("to_err_set", bus.err, 1);
    chk("to_rdy_a_back", bus.rdy_a, 1);
    chk("to_rdy_b_still_full", bus.rdy_b, 0);
    bus.net_busy = 0;
    cyc(1);
    chk("to_b_served_val", bus.val_n, 1);
    chk("to_b_served_d1", bus.data1_n, 4'hE);
    cyc(1);
    chk("to_b_done", bus.val_n, 0);
    chk("to_err_sticky", bus.err, 1);
    chk("to_sb_empty", sb.size(), 0);

    // Reset in the middle of a write: message dropped, err not raised
    bus.val_a = 1; bus.data1_a = 4'h2; bus.data2_a = 4'h9;
    bus.net_busy = 1;
    cyc(1);
    bus.val_a = 0;
    cyc(1);
    chk("mid_val_before", bus.val_n, 1);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_val", bus.val_n, 0);
    chk("mid_rst_rdy_a", bus.rdy_a, 0);
    chk("mid_rst_rdy_b", bus.rdy_b, 0);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_d1", bus.data1_n, 0);
    cyc(1);
    rst_n = 1;
    bus.net_busy = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("mid_no_stale_val", bus.val_n, 0);
      chk("mid_err_clear", bus.err, 0);
    end
    chk("mid_rdy_a", bus.rdy_a, 1);
    chk("mid_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
